// File: rtl/bcd_updown_cnt4.sv
// Four-digit BCD up/down counter (0000-9999) advanced by a one-cycle tick strobe.
// Supports pause, direction, clamped parallel load, clear, and wrap or saturate at the ends.
module bcd_updown_cnt4 #(
  parameter bit                WRAP_EN  = 1'b1,
  parameter logic [15:0]       INIT_VAL = 16'h0000,
  localparam int unsigned      DW       = 4,
  localparam int unsigned      ND       = 4,
  localparam int unsigned      VW       = DW * ND
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          en,
  input  logic          up_dn,
  input  logic          clr,
  input  logic          load,
  input  logic [VW-1:0] load_val,
  output logic [DW-1:0] digit0,
  output logic [DW-1:0] digit1,
  output logic [DW-1:0] digit2,
  output logic [DW-1:0] digit3,
  output logic          wrap,
  output logic          at_limit
);

  localparam logic [DW-1:0] NINE = DW'(9);

  logic [ND-1:0][DW-1:0] cnt_q;
  logic [ND-1:0][DW-1:0] cnt_d;
  logic [ND-1:0][DW-1:0] step;
  logic                  carry;
  logic                  wrap_d;

  // Any nibble above 9 is forced to 9 so stored digits stay valid BCD.
  function automatic logic [DW-1:0] clamp_bcd(input logic [DW-1:0] nib);
    return (nib > NINE) ? NINE : nib;
  endfunction

  // One-step count with carry/borrow rippling through all digits in one cycle.
  always_comb begin
    step  = cnt_q;
    carry = 1'b1;
    for (int i = 0; i < int'(ND); i++) begin
      if (carry) begin
        if (up_dn) begin
          if (cnt_q[i] >= NINE) begin
            step[i] = '0;
          end else begin
            step[i] = cnt_q[i] + DW'(1);
            carry   = 1'b0;
          end
        end else begin
          if (cnt_q[i] == '0) begin
            step[i] = NINE;
          end else begin
            step[i] = clamp_bcd(cnt_q[i] - DW'(1));
            carry   = 1'b0;
          end
        end
      end
    end
  end

  // Next value: clr > load > qualified tick > hold. Carry out of d3 marks an end-of-range step.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      for (int i = 0; i < int'(ND); i++) begin
        cnt_d[i] = clamp_bcd(load_val[i*DW +: DW]);
      end
    end else if (tick && en) begin
      if (!carry) begin
        cnt_d = step;
      end else if (WRAP_EN) begin
        cnt_d  = step;
        wrap_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ND); i++) begin
        cnt_q[i] <= clamp_bcd(INIT_VAL[i*DW +: DW]);
      end
      wrap <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wrap  <= wrap_d;
    end
  end

  assign digit0   = cnt_q[0];
  assign digit1   = cnt_q[1];
  assign digit2   = cnt_q[2];
  assign digit3   = cnt_q[3];
  assign at_limit = up_dn ? (cnt_q == VW'(16'h9999)) : (cnt_q == '0);

endmodule
